// File: rtl/msi_pkg.sv
// Shared encodings for the MSI snooping bus: bus transaction types and the
// controller state enum.
package msi_pkg;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      BUSRD   = 2'd1,
      BUSRDX  = 2'd2,
      BUSUPGR = 2'd3
   } bus_op_e;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SNOOP    = 3'd1,
      COLLECT  = 3'd2,
      MEM_WAIT = 3'd3,
      RESP     = 3'd4
   } bus_state_e;

endpackage

// File: rtl/msi_bus_arbiter.sv
// Request arbiter for the snooping bus. MSI_SNOOP_BUS_RR_EN selects round-robin
// (search starts after the last winner); otherwise fixed lowest-index priority.
module msi_bus_arbiter #(
   parameter int NUM_CORES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_CORES-1:0] req,
   input  logic                 accept,
   output logic [NUM_CORES-1:0] grant
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] nxt_ptr;
   logic             found;
   int               pos;

   // Circular search from ptr_q; in fixed-priority builds ptr_q never leaves 0.
   always_comb begin
      grant   = '0;
      cand    = '0;
      nxt_ptr = '0;
      found   = 1'b0;
      pos     = 0;
      for (int i = 0; i < NUM_CORES; i++) begin
         pos = int'(ptr_q) + i;
         if (pos >= NUM_CORES) pos = pos - NUM_CORES;
         cand = IDX_W'(pos);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
`ifdef MSI_SNOOP_BUS_RR_EN
            nxt_ptr = (pos == NUM_CORES - 1) ? '0 : IDX_W'(pos + 1);
`else
            nxt_ptr = '0;
`endif
         end
      end
      ptr_d = accept ? nxt_ptr : ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/msi_snoop_bus.sv
// MSI snooping bus controller: serialises cache misses/upgrades, broadcasts
// snoops, collects flushes or memory data. Arbitration set by MSI_SNOOP_BUS_RR_EN.
module msi_snoop_bus
   import msi_pkg::*;
#(
   parameter int NUM_CORES = 2,
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CORES-1:0]        req_valid,
   input  logic [2*NUM_CORES-1:0]      req_type,
   input  logic [ADDR_W*NUM_CORES-1:0] req_addr,
   output logic                        snoop_valid,
   output logic [1:0]                  snoop_type,
   output logic [ADDR_W-1:0]           snoop_addr,
   output logic [NUM_CORES-1:0]        snoop_src,
   input  logic [NUM_CORES-1:0]        snp_flush,
   input  logic [DATA_W*NUM_CORES-1:0] snp_data,
   output logic                        mem_rd_en,
   output logic [ADDR_W-1:0]           mem_rd_addr,
   input  logic [DATA_W-1:0]           mem_rd_data,
   output logic                        mem_wr_en,
   output logic [ADDR_W-1:0]           mem_wr_addr,
   output logic [DATA_W-1:0]           mem_wr_data,
   input  logic [NUM_CORES-1:0]        wb_valid,
   input  logic [ADDR_W*NUM_CORES-1:0] wb_addr,
   input  logic [DATA_W*NUM_CORES-1:0] wb_data,
   output logic [NUM_CORES-1:0]        wb_ready,
   output logic [NUM_CORES-1:0]        resp_valid,
   output logic [DATA_W-1:0]           resp_data
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   bus_state_e       state_q, state_d;
   logic [IDX_W-1:0] src_q, src_d;
   bus_op_e          type_q, type_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   logic [NUM_CORES-1:0] req_bits, grant, src_oh;
   logic [IDX_W-1:0]     grant_idx, wb_idx, flush_idx;
   logic                 accept, wb_any, flush_any;

   // A request with type NONE is not a request at all.
   always_comb begin
      req_bits = '0;
      for (int i = 0; i < NUM_CORES; i++)
         req_bits[i] = req_valid[i] && (req_type[2*i +: 2] != NONE);
   end

   msi_bus_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_bits),
      .accept (accept),
      .grant  (grant)
   );

   // Descending scan so the lowest index is the last one written.
   always_comb begin
      wb_any    = 1'b0;
      wb_idx    = '0;
      flush_any = 1'b0;
      flush_idx = '0;
      grant_idx = '0;
      src_oh    = '0;
      src_oh[src_q] = 1'b1;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (wb_valid[i]) begin
            wb_any = 1'b1;
            wb_idx = IDX_W'(i);
         end
         if (snp_flush[i] && !src_oh[i]) begin
            flush_any = 1'b1;
            flush_idx = IDX_W'(i);
         end
         if (grant[i]) grant_idx = IDX_W'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      type_d      = type_q;
      addr_d      = addr_q;
      data_d      = data_q;
      accept      = 1'b0;
      snoop_valid = 1'b0;
      snoop_type  = '0;
      snoop_addr  = '0;
      snoop_src   = '0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      mem_wr_en   = 1'b0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
      wb_ready    = '0;
      resp_valid  = '0;
      resp_data   = '0;
      // Outputs are gated by rst_n so they fall to 0 the moment reset asserts.
      if (rst_n) begin
         case (state_q)
            IDLE: begin
               if (wb_any) begin
                  wb_ready[wb_idx] = 1'b1;
                  mem_wr_en        = 1'b1;
                  mem_wr_addr      = wb_addr[int'(wb_idx)*ADDR_W +: ADDR_W];
                  mem_wr_data      = wb_data[int'(wb_idx)*DATA_W +: DATA_W];
               end else if (|req_bits) begin
                  accept  = 1'b1;
                  src_d   = grant_idx;
                  type_d  = bus_op_e'(req_type[int'(grant_idx)*2 +: 2]);
                  addr_d  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                  state_d = SNOOP;
               end
            end
            SNOOP: begin
               snoop_valid = 1'b1;
               snoop_type  = type_q;
               snoop_addr  = addr_q;
               snoop_src   = src_oh;
               state_d     = COLLECT;
            end
            COLLECT: begin
               if (flush_any) begin
                  mem_wr_en   = 1'b1;
                  mem_wr_addr = addr_q;
                  mem_wr_data = snp_data[int'(flush_idx)*DATA_W +: DATA_W];
                  data_d      = snp_data[int'(flush_idx)*DATA_W +: DATA_W];
                  state_d     = RESP;
               end else if (type_q == BUSUPGR) begin
                  data_d  = '0;
                  state_d = RESP;
               end else begin
                  mem_rd_en   = 1'b1;
                  mem_rd_addr = addr_q;
                  state_d     = MEM_WAIT;
               end
            end
            MEM_WAIT: begin
               data_d  = mem_rd_data;
               state_d = RESP;
            end
            RESP: begin
               resp_valid[src_q] = 1'b1;
               resp_data         = data_q;
               state_d           = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         type_q  <= NONE;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         type_q  <= type_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: doc/msi_snoop_bus.md
MSI_SNOOP_BUS -- requirements
Module: msi_snoop_bus

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2: number of attached caches, legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 9: line address width.
REQ-003 SHALL have parameter DATA_W, default 32: line data width.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  in  NUM_CORES: per-cache miss/upgrade request, held until resp_valid.
REQ-007 SHALL have port req_type  in  2*NUM_CORES: per cache, 0=none, 1=BusRd, 2=BusRdX, 3=BusUpgr.
REQ-008 SHALL have port req_addr  in  ADDR_W*NUM_CORES: per-cache request address.
REQ-009 SHALL have ports snoop_valid out 1, snoop_type out 2, snoop_addr out ADDR_W, snoop_src out NUM_CORES: one-hot broadcast of the granted transaction.
REQ-010 SHALL have ports snp_flush in NUM_CORES, snp_data in DATA_W*NUM_CORES: cache holding the line in M supplies data and drops to S (BusRd) or I (BusRdX).
REQ-011 SHALL have ports mem_rd_en out 1, mem_rd_addr out ADDR_W, mem_rd_data in DATA_W: one-cycle-latency memory read.
REQ-012 SHALL have ports mem_wr_en out 1, mem_wr_addr out ADDR_W, mem_wr_data out DATA_W: single memory write port.
REQ-013 SHALL have ports wb_valid in NUM_CORES, wb_addr in ADDR_W*NUM_CORES, wb_data in DATA_W*NUM_CORES, wb_ready out NUM_CORES: eviction write-backs.
REQ-014 SHALL have ports resp_valid out NUM_CORES, resp_data out DATA_W: one-hot completion pulse and line data.

Function
REQ-015 SHALL run FSM states IDLE, SNOOP, COLLECT, MEM_WAIT, RESP.
REQ-016 SHALL, in IDLE with any wb_valid, serve the lowest-index write-back first: wb_ready pulse 1 cycle, mem_wr_en with its addr/data that cycle, remain in IDLE.
REQ-017 SHALL, in IDLE with no wb_valid and any req_valid, latch winner index, type and addr, and go to SNOOP.
REQ-018 SHALL, in SNOOP, drive snoop_valid=1 for exactly one cycle with latched type/addr and one-hot snoop_src, then go to COLLECT.
REQ-019 SHALL, in COLLECT, ignore snp_flush of the requester; if any other snp_flush, take data from the lowest-index flusher, write it to memory (mem_wr_en same cycle), and go to RESP.
REQ-020 SHALL, in COLLECT with no flush: BusUpgr goes to RESP with resp_data=0; BusRd/BusRdX assert mem_rd_en for one cycle and go to MEM_WAIT.
REQ-021 SHALL, in MEM_WAIT, capture mem_rd_data into the response register and go to RESP.
REQ-022 SHALL, in RESP, pulse resp_valid for the granted cache only, hold resp_data valid that cycle, and return to IDLE.
REQ-023 SHALL give latency from req sampled in IDLE at edge T: resp_valid at T+3 (cache flush/upgrade), T+4 (memory).
REQ-024 SHALL not re-grant a cache in the cycle its resp_valid is high.
REQ-025 SHALL ignore req_valid whose req_type is 0.
REQ-026 SHALL keep exactly one transaction outstanding; mem_rd_en and mem_wr_en are never both high.

Reset
REQ-027 SHALL, on rst_n low at any time (including mid-transaction), enter IDLE immediately and drive all outputs 0, drop the in-flight transaction, and reset the arbitration pointer to 0.
REQ-028 SHALL resume arbitration on the first rising clk edge after rst_n deasserts.

Configuration
REQ-029 SHALL honour macro MSI_SNOOP_BUS_RR_EN: defined -> round-robin request arbitration, search starts at index after last winner; undefined -> fixed priority, lowest index wins; write-back selection is lowest-index in both.

Structure
REQ-030 SHALL place bus transaction encodings (NONE, BUSRD, BUSRDX, BUSUPGR) and the FSM state enum in shared package msi_pkg.
REQ-031 SHALL implement request selection in sub-module msi_bus_arbiter (NUM_CORES request bits in, one-hot grant out, pointer update on accept).

Verification
REQ-032 SHALL check: core0 BusRd 0x05, no flush, mem returns 0xDEADBEEF -> mem_rd_en at T+2, resp_valid=01 at T+4, resp_data=0xDEADBEEF.
REQ-033 SHALL check: core1 BusRdX 0x10, core0 flushes 0x12345678 -> mem_wr_en addr 0x10 data 0x12345678 at T+2, resp_valid=10 at T+3, no mem_rd_en.
REQ-034 SHALL check: core0 BusUpgr 0x03 -> snoop_valid 1 cycle at T+1, resp_valid=01 at T+3, resp_data=0.
REQ-035 SHALL check: both cores request continuously with MSI_SNOOP_BUS_RR_EN defined -> grants alternate 0,1,0,1; undefined -> core0 wins whenever requesting.
REQ-036 SHALL check: wb_valid core1 (0x1F, 0xA5A5A5A5) coincident with core0 BusRd -> write-back served first, request granted next IDLE cycle.
REQ-037 SHALL check: rst_n low during MEM_WAIT -> all outputs 0 asynchronously, no resp_valid after release, next request completes normally.
